pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage core. Merges the ID hazard stall/flush, the data-memory
//  wait handshake and the multi-cycle mul/div unit in EX into one set of per-stage load/bubble controls.
//  Sequences mul/div start/done and flags data-memory wait timeouts. Sits between hazard_unit, the
//  pipeline registers, the PC register, the D-mem port and the mul/div unit.
// PARAMETERS
//  MEM_TIMEOUT  256  consecutive mem-stall cycles that set err_mem_timeout (>=1)
//  CNT_W        32   perf counter width (used only with PIPE_PERF_CNT_EN)
// PORTS
//  clk              in   1      core clock, all state on rising edge
//  rst_n            in   1      asynchronous, active-low reset
//  hz_stall         in   1      ID stall request from hazard unit (level)
//  hz_flush         in   1      ID branch-mispredict flush request (level)
//  dmem_req         in   1      MEM stage has an active D-mem access
//  dmem_ready       in   1      D-mem completes access this cycle
//  ex_is_md         in   1      instruction in EX is mul/div
//  md_done          in   1      mul/div result valid (1-cycle pulse)
//  md_start         out  1      1-cycle start pulse to mul/div
//  pc_en            out  1      PC register load enable
//  pc_redirect      out  1      PC loads branch-correction target
//  ifid_en          out  1      IF/ID load enable
//  ifid_flush       out  1      IF/ID loads NOP
//  idex_en          out  1      ID/EX load enable
//  idex_bubble      out  1      ID/EX loads zero control
//  exmem_en         out  1      EX/MEM load enable
//  exmem_bubble     out  1      EX/MEM loads zero control
//  memwb_en         out  1      MEM/WB load enable
//  memwb_bubble     out  1      MEM/WB loads zero control
//  err_mem_timeout  out  1      sticky D-mem timeout flag
//  perf_stall_cyc   out  CNT_W  cycles with pc_en=0 (perf)
//  perf_flush_cnt   out  CNT_W  honoured flushes (perf)
// BEHAVIOUR
//  - While rst_n=0: all *_en, *_bubble, ifid_flush, pc_redirect, md_start = 0.
//    Also: state=RUN; err_mem_timeout=0; wait counter=0; perf counters=0.
//  - mem_stall = dmem_req & ~dmem_ready.
//  - FSM states: RUN, EX_WAIT, EX_HOLD.
//    RUN: ex_is_md -> md_start=1, go EX_WAIT.
//    EX_WAIT: md_done & ~mem_stall -> RUN; md_done & mem_stall -> EX_HOLD.
//    EX_HOLD: ~mem_stall -> RUN.
//  - md_start only in RUN. md_done is never expected in the start cycle; md_done outside EX_WAIT is ignored.
//  - ex_stall = (RUN & ex_is_md) | (EX_WAIT & ~md_done). EX_HOLD does not stall EX itself.
//  - Stage controls, combinational, strict priority:
//    1 mem_stall: pc,ifid,idex,exmem en=0; memwb_en=1, memwb_bubble=1.
//    2 ex_stall: pc,ifid,idex en=0; exmem_en=1, exmem_bubble=1; memwb_en=1.
//    3 hz_stall: pc,ifid en=0; idex_en=1, idex_bubble=1; exmem, memwb en=1.
//    4 else: all en=1, no bubbles. If hz_flush: ifid_flush=1, pc_redirect=1.
//  - hz_flush is honoured only in case 4. In cases 1-3 it is dropped, because the branch stays in ID
//    and re-asserts.
//  - Bubble/flush asserted only together with the same stage's en=1.
//  - Wait counter: +1 each mem_stall cycle, cleared on any non-stall cycle.
//    Reaching MEM_TIMEOUT sets err_mem_timeout; the counter saturates there and the stall continues.
//    The flag clears only on reset.
//  - Reset mid-md: FSM returns to RUN. Any later md_done is ignored until the next md_start.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined:
//    - perf_stall_cyc +1 per cycle with pc_en=0.
//    - perf_flush_cnt +1 per honoured flush.
//    - Both saturate at all-ones.
//  PIPE_PERF_CNT_EN undefined: both outputs tied 0, no counter flops.
// TESTING
//  T1 mem stall: dmem_req=1, dmem_ready=0 for 3 cycles while ex_is_md=0.
//     -> pc/ifid/idex/exmem en=0 and memwb_bubble=1 for 3 cycles; all en=1 on the ready cycle.
//  T2 mul/div: ex_is_md=1 in RUN, md_done on cycle 4.
//     -> md_start=1 on cycle 0 only; exmem_bubble=1 on cycles 0-3; exmem_en=1, no bubble on cycle 4; RUN on cycle 5.
//  T3 md_done with mem_stall=1 for 2 more cycles.
//     -> EX_HOLD for 2 cycles with no md_start; RUN after dmem_ready; exactly one md_start total.
//  T4 hz_flush together with mem_stall -> no pc_redirect; hz_flush alone next cycle -> ifid_flush=pc_redirect=1.
//  T5 MEM_TIMEOUT=4, 6-cycle mem stall -> err_mem_timeout rises after 4th stall cycle, stays 1 after ready.
//     Pulse rst_n low -> flag 0, all en 0 during reset.
//  T6 PIPE_PERF_CNT_EN, CNT_W=4: 20 stall cycles -> perf_stall_cyc=15. Macro undefined -> perf_* stay 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Pipeline sequencer signal bundle: hazard, D-mem and mul/div handshakes plus per-stage controls.
`default_nettype none

interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             hz_stall;
    logic             hz_flush;
    logic             dmem_req;
    logic             dmem_ready;
    logic             ex_is_md;
    logic             md_done;
    logic             md_start;
    logic             pc_en;
    logic             pc_redirect;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_bubble;
    logic             exmem_en;
    logic             exmem_bubble;
    logic             memwb_en;
    logic             memwb_bubble;
    logic             err_mem_timeout;
    logic [CNT_W-1:0] perf_stall_cyc;
    logic [CNT_W-1:0] perf_flush_cnt;

    modport slave (
        input  hz_stall, hz_flush, dmem_req, dmem_ready, ex_is_md, md_done,
        output md_start, pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_bubble,
               exmem_en, exmem_bubble, memwb_en, memwb_bubble, err_mem_timeout,
               perf_stall_cyc, perf_flush_cnt
    );

    modport master (
        output hz_stall, hz_flush, dmem_req, dmem_ready, ex_is_md, md_done,
        input  md_start, pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_bubble,
               exmem_en, exmem_bubble, memwb_en, memwb_bubble, err_mem_timeout,
               perf_stall_cyc, perf_flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module  : pipeline_ctrl
// Brief   : 5-stage pipeline sequencer merging ID hazards, D-mem wait and
//           mul/div sequencing into per-stage load/bubble controls.
//           Optional perf counters under macro PIPE_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pipeline_ctrl_if.slave  ctrl
);

    localparam int                  c_wait_w     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_timeout    = c_wait_w'(MEM_TIMEOUT);
    localparam logic [c_wait_w-1:0] c_timeout_m1 = c_wait_w'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        EX_WAIT = 2'd1,
        EX_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_md_start;
    logic                w_mem_stall;
    logic                w_ex_stall;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                r_err;

    logic w_pc_en, w_pc_redirect, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_bubble;
    logic w_exmem_en, w_exmem_bubble, w_memwb_en, w_memwb_bubble;

    assign w_mem_stall = ctrl.dmem_req & ~ctrl.dmem_ready;
    assign w_ex_stall  = ((r_state == RUN) & ctrl.ex_is_md) |
                         ((r_state == EX_WAIT) & ~ctrl.md_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_md_start  = 1'b0;
        case (r_state)
            RUN: begin
                if (ctrl.ex_is_md) begin
                    w_md_start  = 1'b1;
                    w_state_nxt = EX_WAIT;
                end
            end
            EX_WAIT: begin
                // Result arrived but MEM is blocked: hold EX until the stall lifts
                if (ctrl.md_done) begin
                    w_state_nxt = w_mem_stall ? EX_HOLD : RUN;
                end
            end
            EX_HOLD: begin
                if (!w_mem_stall) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_pc_en        = 1'b0;
        w_pc_redirect  = 1'b0;
        w_ifid_en      = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_en      = 1'b0;
        w_idex_bubble  = 1'b0;
        w_exmem_en     = 1'b0;
        w_exmem_bubble = 1'b0;
        w_memwb_en     = 1'b0;
        w_memwb_bubble = 1'b0;
        if (rst_n) begin
            if (w_mem_stall) begin
                w_memwb_en     = 1'b1;
                w_memwb_bubble = 1'b1;
            end else if (w_ex_stall) begin
                w_exmem_en     = 1'b1;
                w_exmem_bubble = 1'b1;
                w_memwb_en     = 1'b1;
            end else if (ctrl.hz_stall) begin
                w_idex_en     = 1'b1;
                w_idex_bubble = 1'b1;
                w_exmem_en    = 1'b1;
                w_memwb_en    = 1'b1;
            end else begin
                // A flush dropped in a stalled cycle is re-raised by the branch still in ID
                w_pc_en       = 1'b1;
                w_ifid_en     = 1'b1;
                w_idex_en     = 1'b1;
                w_exmem_en    = 1'b1;
                w_memwb_en    = 1'b1;
                w_pc_redirect = ctrl.hz_flush;
                w_ifid_flush  = ctrl.hz_flush;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else if (w_mem_stall) begin
            if (r_wait_cnt != c_timeout) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_wait_cnt >= c_timeout_m1) begin
                r_err <= 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign ctrl.md_start        = w_md_start & rst_n;
    assign ctrl.pc_en           = w_pc_en;
    assign ctrl.pc_redirect     = w_pc_redirect;
    assign ctrl.ifid_en         = w_ifid_en;
    assign ctrl.ifid_flush      = w_ifid_flush;
    assign ctrl.idex_en         = w_idex_en;
    assign ctrl.idex_bubble     = w_idex_bubble;
    assign ctrl.exmem_en        = w_exmem_en;
    assign ctrl.exmem_bubble    = w_exmem_bubble;
    assign ctrl.memwb_en        = w_memwb_en;
    assign ctrl.memwb_bubble    = w_memwb_bubble;
    assign ctrl.err_mem_timeout = r_err;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (!w_pc_en && (r_perf_stall != {CNT_W{1'b1}})) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
            if (w_pc_redirect && (r_perf_flush != {CNT_W{1'b1}})) begin
                r_perf_flush <= r_perf_flush + 1'b1;
            end
        end
    end

    assign ctrl.perf_stall_cyc = r_perf_stall;
    assign ctrl.perf_flush_cnt = r_perf_flush;
`else
    assign ctrl.perf_stall_cyc = {CNT_W{1'b0}};
    assign ctrl.perf_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table of single-cycle vectors plus multi-cycle sequences.
`default_nettype none

module tb_pipeline_ctrl;

    localparam int c_cnt_w = 4;

    // inputs {hz_stall, hz_flush, dmem_req, dmem_ready, ex_is_md, md_done}
    localparam logic [5:0] I_NO = 6'b000000;
    localparam logic [5:0] I_HZ = 6'b100000;
    localparam logic [5:0] I_FL = 6'b010000;
    localparam logic [5:0] I_MS = 6'b001000;
    localparam logic [5:0] I_MR = 6'b001100;
    localparam logic [5:0] I_RD = 6'b000100;
    localparam logic [5:0] I_MD = 6'b000010;
    localparam logic [5:0] I_DN = 6'b000001;

    // outputs {md_start, pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_bubble,
    //          exmem_en, exmem_bubble, memwb_en, memwb_bubble}
    localparam logic [10:0] E_RUN  = 11'b01010101010;
    localparam logic [10:0] E_FLSH = 11'b01111101010;
    localparam logic [10:0] E_MEM  = 11'b00000000011;
    localparam logic [10:0] E_EX   = 11'b00000001110;
    localparam logic [10:0] E_EXST = 11'b10000001110;
    localparam logic [10:0] E_HZ   = 11'b00000111010;
    localparam logic [10:0] E_RST  = 11'b00000000000;

    typedef struct packed {
        logic [5:0]  in;
        logic [10:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [10:0] exp_q[$];
    vec_t tbl[10];

    pipeline_ctrl_if #(.CNT_W(c_cnt_w)) bus ();

    pipeline_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (c_cnt_w)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctrl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] dut_out();
        return {bus.md_start, bus.pc_en, bus.pc_redirect, bus.ifid_en, bus.ifid_flush,
                bus.idex_en, bus.idex_bubble, bus.exmem_en, bus.exmem_bubble,
                bus.memwb_en, bus.memwb_bubble};
    endfunction

    task automatic set_in(input logic [5:0] in);
        {bus.hz_stall, bus.hz_flush, bus.dmem_req, bus.dmem_ready, bus.ex_is_md, bus.md_done} = in;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One cycle: drive after the edge, compare controls at the falling edge.
    // exp_err < 0 means the timeout flag is not checked this cycle.
    task automatic step(input string name, input logic [5:0] in, input logic [10:0] exp,
                        input int exp_err);
        logic [10:0] e;
        set_in(in);
        exp_q.push_back(exp);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            chk(name, 32'(dut_out()), 32'(e));
        end
        if (exp_err >= 0) chk({name, "_err"}, 32'(bus.err_mem_timeout), exp_err[31:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        set_in(I_MD | I_MS | I_FL);
        @(negedge clk);
        chk({name, "_ctrl"}, 32'(dut_out()), 32'(E_RST));
        chk({name, "_err"}, 32'(bus.err_mem_timeout), 32'd0);
        chk({name, "_perf_stall"}, 32'(bus.perf_stall_cyc), 32'd0);
        chk({name, "_perf_flush"}, 32'(bus.perf_flush_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        set_in(I_NO);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        tbl[0] = '{in: I_NO,               exp: E_RUN};
        tbl[1] = '{in: I_FL,               exp: E_FLSH};
        tbl[2] = '{in: I_HZ,               exp: E_HZ};
        tbl[3] = '{in: I_HZ | I_FL,        exp: E_HZ};
        tbl[4] = '{in: I_MS,               exp: E_MEM};
        tbl[5] = '{in: I_MR,               exp: E_RUN};
        tbl[6] = '{in: I_RD,               exp: E_RUN};
        tbl[7] = '{in: I_MS | I_HZ | I_FL, exp: E_MEM};
        tbl[8] = '{in: I_DN,               exp: E_RUN};
        tbl[9] = '{in: I_MR | I_FL,        exp: E_FLSH};

        do_reset("reset0");

        for (int i = 0; i < 10; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].in, tbl[i].exp, 0);
        end

        // T1: three-cycle memory stall, released by ready
        for (int i = 0; i < 3; i++) step($sformatf("t1_stall%0d", i), I_MS, E_MEM, 0);
        step("t1_ready", I_MR, E_RUN, 0);

        // T2: mul/div completes on cycle 4; RUN shown by a fresh start on cycle 5
        step("t2_c0", I_MD, E_EXST, -1);
        for (int i = 1; i < 4; i++) step($sformatf("t2_c%0d", i), I_MD, E_EX, -1);
        step("t2_c4", I_MD | I_DN, E_RUN, -1);
        step("t2_c5", I_MD, E_EXST, -1);
        step("t2_c6", I_MD | I_DN, E_RUN, -1);
        step("t2_idle", I_NO, E_RUN, -1);

        // T3: md_done while MEM stalls -> EX_HOLD for two cycles, no restart
        step("t3_c0", I_MD, E_EXST, -1);
        step("t3_c1", I_MD | I_DN | I_MS, E_MEM, 0);
        step("t3_hold0", I_MD | I_MS, E_MEM, 0);
        step("t3_hold1", I_MD | I_MS, E_MEM, 0);
        step("t3_ready", I_MD | I_MR, E_RUN, 0);
        step("t3_idle", I_NO, E_RUN, 0);

        // T4: flush dropped under mem stall, honoured alone
        step("t4_drop", I_FL | I_MS, E_MEM, -1);
        step("t4_take", I_FL, E_FLSH, -1);

        // T5: md in flight, then 6-cycle stall crosses MEM_TIMEOUT=4
        step("t5_start", I_MD, E_EXST, 0);
        for (int i = 0; i < 6; i++) step($sformatf("t5_stall%0d", i), I_MD | I_MS, E_MEM, (i >= 4) ? 1 : 0);
        step("t5_ready", I_MD | I_MR, E_EX, 1);
        step("t5_after", I_MD, E_EX, 1);
        do_reset("reset1");

        // Reset mid-md: stray md_done ignored, next md starts from RUN
        step("rst_stray_done", I_DN, E_RUN, 0);
        step("rst_restart", I_MD, E_EXST, 0);
        step("rst_finish", I_MD | I_DN, E_RUN, 0);
        do_reset("reset2");

        // T6: two flushes then 20 stall cycles with a 4-bit counter
        step("t6_fl0", I_FL, E_FLSH, -1);
        step("t6_fl1", I_FL, E_FLSH, -1);
        for (int i = 0; i < 20; i++) step($sformatf("t6_stall%0d", i), I_MS, E_MEM, -1);
        step("t6_ready", I_MR, E_RUN, 1);
`ifdef PIPE_PERF_CNT_EN
        chk("t6_perf_stall", 32'(bus.perf_stall_cyc), 32'd15);
        chk("t6_perf_flush", 32'(bus.perf_flush_cnt), 32'd2);
`else
        chk("t6_perf_stall", 32'(bus.perf_stall_cyc), 32'd0);
        chk("t6_perf_flush", 32'(bus.perf_flush_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
